// File: rtl/exers_mcalu_if.sv
// Dispatch, writeback, flush and mcalu issue bundle for the mcalu reservation station.
// The slave modport is the station's view; master is the surrounding pipeline or testbench.
interface exers_mcalu_if;
    logic        dispatch_valid;
    logic [4:0]  dispatch_op;
    logic [6:0]  dispatch_robid;
    logic [5:0]  dispatch_rd;
    logic        dispatch_op1_rdy;
    logic        dispatch_op2_rdy;
    logic [31:0] dispatch_op1;
    logic [31:0] dispatch_op2;
    logic        exers_stall;

    logic        exers_mcalu_issue;
    logic [4:0]  exers_mcalu_op;
    logic [6:0]  exers_robid;
    logic [5:0]  exers_rd;
    logic [31:0] exers_op1;
    logic [31:0] exers_op2;
    logic        mcalu_stall;

    logic        wb_valid;
    logic [6:0]  wb_robid;
    logic [31:0] wb_result;
    logic        rob_flush;

    modport slave (
        input  dispatch_valid, dispatch_op, dispatch_robid, dispatch_rd,
        input  dispatch_op1_rdy, dispatch_op2_rdy, dispatch_op1, dispatch_op2,
        output exers_stall,
        output exers_mcalu_issue, exers_mcalu_op, exers_robid, exers_rd, exers_op1, exers_op2,
        input  mcalu_stall,
        input  wb_valid, wb_robid, wb_result, rob_flush
    );

    modport master (
        output dispatch_valid, dispatch_op, dispatch_robid, dispatch_rd,
        output dispatch_op1_rdy, dispatch_op2_rdy, dispatch_op1, dispatch_op2,
        input  exers_stall,
        input  exers_mcalu_issue, exers_mcalu_op, exers_robid, exers_rd, exers_op1, exers_op2,
        output mcalu_stall,
        output wb_valid, wb_robid, wb_result, rob_flush
    );
endinterface

// File: rtl/exers_mcalu.sv
// Collapsing-queue reservation station feeding the multi-cycle ALU; entry 0 is always the oldest.
// Optional same-cycle wakeup-to-issue bypass is enabled by defining EXERS_MCALU_WAKEUP_BYPASS_EN.
module exers_mcalu #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    exers_mcalu_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic        valid;
        logic [4:0]  op;
        logic [6:0]  robid;
        logic [5:0]  rd;
        logic        rdy1;
        logic [31:0] val1;
        logic        rdy2;
        logic [31:0] val2;
    } entry_t;

    entry_t             ent_q [DEPTH];
    entry_t             ent_n [DEPTH];
    entry_t             new_e;
    entry_t             sel_e;
    logic [DEPTH-1:0]   elig;
    logic [IDX_W-1:0]   sel_idx;
    logic               found;
    logic               full;
    logic               retire;
    logic               accept;
    logic               placed;

    // Capture a broadcast into any still-waiting operand whose tag matches.
    function automatic entry_t wake(entry_t e, logic wbv, logic [6:0] tag, logic [31:0] res);
        entry_t r;
        r = e;
        if (wbv && !e.rdy1 && e.val1[6:0] == tag) begin
            r.rdy1 = 1'b1;
            r.val1 = res;
        end
        if (wbv && !e.rdy2 && e.val2[6:0] == tag) begin
            r.rdy2 = 1'b1;
            r.val2 = res;
        end
        return r;
    endfunction

    // Valid entries are always contiguous from slot 0, so the top slot alone tells us "full".
    assign full            = ent_q[DEPTH-1].valid;
    assign bus.exers_stall = full;

`ifdef EXERS_MCALU_WAKEUP_BYPASS_EN
    logic [DEPTH-1:0] m1;
    logic [DEPTH-1:0] m2;
`endif

    always_comb begin : select
        found   = 1'b0;
        sel_idx = '0;
        elig    = '0;
`ifdef EXERS_MCALU_WAKEUP_BYPASS_EN
        m1 = '0;
        m2 = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
`ifdef EXERS_MCALU_WAKEUP_BYPASS_EN
            m1[i]   = bus.wb_valid && !ent_q[i].rdy1 && ent_q[i].val1[6:0] == bus.wb_robid;
            m2[i]   = bus.wb_valid && !ent_q[i].rdy2 && ent_q[i].val2[6:0] == bus.wb_robid;
            elig[i] = ent_q[i].valid && (ent_q[i].rdy1 || m1[i]) && (ent_q[i].rdy2 || m2[i]);
`else
            elig[i] = ent_q[i].valid && ent_q[i].rdy1 && ent_q[i].rdy2;
`endif
            if (elig[i] && !found) begin
                found   = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end

    assign sel_e                 = ent_q[sel_idx];
    assign bus.exers_mcalu_issue = found;
    assign bus.exers_mcalu_op    = sel_e.op;
    assign bus.exers_robid       = sel_e.robid;
    assign bus.exers_rd          = sel_e.rd;
`ifdef EXERS_MCALU_WAKEUP_BYPASS_EN
    assign bus.exers_op1 = m1[sel_idx] ? bus.wb_result : sel_e.val1;
    assign bus.exers_op2 = m2[sel_idx] ? bus.wb_result : sel_e.val2;
`else
    assign bus.exers_op1 = sel_e.val1;
    assign bus.exers_op2 = sel_e.val2;
`endif

    always_comb begin : next_state
        retire = found & ~bus.mcalu_stall;
        accept = bus.dispatch_valid & ~full & ~bus.rob_flush;

        // Collapse above the retiring entry; wakeup lands at each entry's new position.
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (retire && i >= int'(sel_idx))
                ent_n[i] = wake(ent_q[i+1], bus.wb_valid, bus.wb_robid, bus.wb_result);
            else
                ent_n[i] = wake(ent_q[i], bus.wb_valid, bus.wb_robid, bus.wb_result);
        end
        if (retire)
            ent_n[DEPTH-1] = '0;
        else
            ent_n[DEPTH-1] = wake(ent_q[DEPTH-1], bus.wb_valid, bus.wb_robid, bus.wb_result);

        new_e.valid = 1'b1;
        new_e.op    = bus.dispatch_op;
        new_e.robid = bus.dispatch_robid;
        new_e.rd    = bus.dispatch_rd;
        new_e.rdy1  = bus.dispatch_op1_rdy;
        new_e.val1  = bus.dispatch_op1;
        new_e.rdy2  = bus.dispatch_op2_rdy;
        new_e.val2  = bus.dispatch_op2;
        new_e       = wake(new_e, bus.wb_valid, bus.wb_robid, bus.wb_result);

        placed = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && !placed && !ent_n[i].valid) begin
                ent_n[i] = new_e;
                placed   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ent_n[i];
            // NOTE: only the valid bits are reset; payload fields are don't-care while invalid,
            // so leaving them unreset keeps the storage plain flops without reset muxes.
            if (rst || bus.rob_flush)
                ent_q[i].valid <= 1'b0;
        end
    end
endmodule
